// File: rtl/dispatch_unit.sv
// dispatch_unit
//   In-order dispatch stage. Pops decoded instructions from the head of the
//   show-ahead instruction buffer and renames registers through an internal
//   busy/src/val file. It issues to the ALU or load reservation stations,
//   resolves jmp/jeq locally, and snoops the CDB to retire register tags.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   ib_empty/ib_data_out/ib_pop   instruction buffer head {pc, inst} and pop strobe
//   ib_flush, branch_taken, branch_target   registered redirect to fetch / fifo
//   alu_rs_avail/tag, ld_rs_avail/tag       free station and its tag
//   alu_issue, ld_issue, issue_*            issue strobes and operand bus
//   cdb_valid/tag/data                      common data bus snoop
//   halted                                  halt instruction reached
module dispatch_unit #(
  parameter int NREGS = 16,
  parameter int TAGW  = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ib_empty,
  input  logic [31:0]     ib_data_out,
  output logic            ib_pop,
  output logic            ib_flush,
  output logic            branch_taken,
  output logic [15:0]     branch_target,
  input  logic            alu_rs_avail,
  input  logic [TAGW-1:0] alu_rs_tag,
  input  logic            ld_rs_avail,
  input  logic [TAGW-1:0] ld_rs_tag,
  output logic            alu_issue,
  output logic            ld_issue,
  output logic [3:0]      issue_op,
  output logic            issue_a_busy,
  output logic            issue_b_busy,
  output logic [TAGW-1:0] issue_a_src,
  output logic [TAGW-1:0] issue_b_src,
  output logic [15:0]     issue_a_val,
  output logic [15:0]     issue_b_val,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_tag,
  input  logic [15:0]     cdb_data,
  output logic            halted
);

  localparam logic [3:0] OP_MOV  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_JMP  = 4'd2;
  localparam logic [3:0] OP_HALT = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_JEQ  = 4'd5;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  state_t state_q, state_d;

  logic            busy_q [NREGS];
  logic [TAGW-1:0] src_q  [NREGS];
  logic [15:0]     val_q  [NREGS];

  logic            flush_q;
  logic [15:0]     target_q, target_d;

  logic [15:0] pc, inst;
  logic [3:0]  op, ra, rb, rt;
  logic        ra_hit, rb_hit, ra_busy, rb_busy;
  logic [15:0] ra_val, rb_val, jeq_target;
  logic        pop, alu_go, ld_go, rename_en;
  logic [TAGW-1:0] rename_tag;

  assign pc   = ib_data_out[31:16];
  assign inst = ib_data_out[15:0];
  assign op   = inst[15:12];
  assign ra   = inst[11:8];
  assign rb   = inst[7:4];
  assign rt   = inst[3:0];

  // Source read with CDB bypass: a result broadcast this cycle is already usable.
  always_comb begin
    ra_hit  = cdb_valid && busy_q[ra] && (src_q[ra] == cdb_tag);
    rb_hit  = cdb_valid && busy_q[rb] && (src_q[rb] == cdb_tag);
    ra_busy = busy_q[ra] && !ra_hit;
    rb_busy = busy_q[rb] && !rb_hit;
    ra_val  = ra_hit ? cdb_data : val_q[ra];
    rb_val  = rb_hit ? cdb_data : val_q[rb];
  end

  assign jeq_target = pc + 16'd1 + {{12{inst[3]}}, inst[3:0]};

  // State register plus the registered redirect outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      flush_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= (state_d == S_FLUSH);
      target_q <= target_d;
    end
  end

  // Next-state and dispatch decision.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    pop      = 1'b0;
    alu_go   = 1'b0;
    ld_go    = 1'b0;
    if (reset) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!ib_empty) begin
            case (op)
              OP_MOV, OP_ADD: begin
                pop    = alu_rs_avail;
                alu_go = alu_rs_avail;
              end
              OP_LD: begin
                pop   = ld_rs_avail;
                ld_go = ld_rs_avail;
              end
              OP_JMP: begin
                pop      = 1'b1;
                state_d  = S_FLUSH;
                target_d = {4'b0, inst[11:0]};
              end
              OP_JEQ: begin
                if (!ra_busy && !rb_busy) begin
                  pop = 1'b1;
                  if (ra_val == rb_val) begin
                    state_d  = S_FLUSH;
                    target_d = jeq_target;
                  end
                end
              end
              OP_HALT: begin
                pop     = 1'b1;
                state_d = S_HALT;
              end
              default: pop = 1'b1;  // unknown opcodes are dropped
            endcase
          end
        end
        S_FLUSH: state_d = S_RUN;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_RUN;
      endcase
    end
  end

  // Output decode and issue bus.
  always_comb begin
    ib_pop        = pop;
    alu_issue     = alu_go;
    ld_issue      = ld_go;
    ib_flush      = flush_q;
    branch_taken  = flush_q;
    branch_target = target_q;
    halted        = (state_q == S_HALT);
    issue_op      = op;
    issue_a_busy  = ra_busy;
    issue_a_src   = src_q[ra];
    issue_a_val   = ra_val;
    issue_b_busy  = rb_busy;
    issue_b_src   = src_q[rb];
    issue_b_val   = rb_val;
    if (op == OP_MOV) begin
      issue_a_busy = 1'b0;
      issue_a_src  = '0;
      issue_a_val  = {8'b0, inst[11:4]};
    end
    if (op == OP_MOV || op == OP_LD) begin
      issue_b_busy = 1'b0;
      issue_b_src  = '0;
      issue_b_val  = '0;
    end
  end

  assign rename_en  = alu_go || ld_go;
  assign rename_tag = alu_go ? alu_rs_tag : ld_rs_tag;

  // Register file: rename takes priority over a CDB write to the same entry,
  // since the newer producer owns the register from now on.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
    always_ff @(posedge clk) begin
      if (reset) begin
        busy_q[gi] <= 1'b0;
        src_q[gi]  <= '0;
        val_q[gi]  <= '0;
      end else if (rename_en && (rt == 4'(gi))) begin
        busy_q[gi] <= 1'b1;
        src_q[gi]  <= rename_tag;
      end else if (cdb_valid && busy_q[gi] && (src_q[gi] == cdb_tag)) begin
        busy_q[gi] <= 1'b0;
        val_q[gi]  <= cdb_data;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_unit.sv
module tb_dispatch_unit;
  localparam int TAGW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, ib_empty;
  logic [31:0]     ib_data_out;
  logic            ib_pop, ib_flush, branch_taken;
  logic [15:0]     branch_target;
  logic            alu_rs_avail, ld_rs_avail;
  logic [TAGW-1:0] alu_rs_tag, ld_rs_tag;
  logic            alu_issue, ld_issue;
  logic [3:0]      issue_op;
  logic            issue_a_busy, issue_b_busy;
  logic [TAGW-1:0] issue_a_src, issue_b_src;
  logic [15:0]     issue_a_val, issue_b_val;
  logic            cdb_valid;
  logic [TAGW-1:0] cdb_tag;
  logic [15:0]     cdb_data;
  logic            halted;

  dispatch_unit #(.NREGS(16), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .ib_empty(ib_empty), .ib_data_out(ib_data_out),
    .ib_pop(ib_pop), .ib_flush(ib_flush), .branch_taken(branch_taken),
    .branch_target(branch_target), .alu_rs_avail(alu_rs_avail), .alu_rs_tag(alu_rs_tag),
    .ld_rs_avail(ld_rs_avail), .ld_rs_tag(ld_rs_tag), .alu_issue(alu_issue),
    .ld_issue(ld_issue), .issue_op(issue_op), .issue_a_busy(issue_a_busy),
    .issue_b_busy(issue_b_busy), .issue_a_src(issue_a_src), .issue_b_src(issue_b_src),
    .issue_a_val(issue_a_val), .issue_b_val(issue_b_val), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .halted(halted)
  );

  // Architectural model: register state, pending redirect, halt flag, fifo contents.
  logic            m_busy [16];
  logic [TAGW-1:0] m_src  [16];
  logic [15:0]     m_val  [16];
  bit              m_flush, m_halted;
  logic [15:0]     m_target;
  logic [31:0]     q[$];
  logic [TAGW-1:0] pend[$];
  bit              gate;

  // Per-cycle expectations and planned model updates.
  bit              e_pop, e_alu, e_ld, e_ren, n_flush, n_halt;
  logic [3:0]      e_rt;
  logic [TAGW-1:0] e_tag;
  logic [15:0]     n_target;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void rd(input logic [3:0] r, output logic b, output logic [TAGW-1:0] s,
                             output logic [15:0] v);
    if (m_busy[r] && cdb_valid && m_src[r] == cdb_tag) begin
      b = 1'b0; s = m_src[r]; v = cdb_data;
    end else begin
      b = m_busy[r]; s = m_src[r]; v = m_val[r];
    end
  endfunction

  // Drive fifo head, compute what the outputs must be, and compare.
  task automatic eval_cycle();
    logic [3:0] op, ra, rb;
    logic ab, bb;
    logic [TAGW-1:0] as_, bs;
    logic [15:0] av, bv, pc;
    int off;
    ib_empty    = gate || (q.size() == 0);
    ib_data_out = (q.size() != 0) ? q[0] : 32'h0;
    #1;
    e_pop = 0; e_alu = 0; e_ld = 0; e_ren = 0;
    n_flush = 0; n_halt = m_halted; n_target = m_target;
    ab = 0; bb = 0; as_ = '0; bs = '0; av = '0; bv = '0;
    op = ib_data_out[15:12]; ra = ib_data_out[11:8]; rb = ib_data_out[7:4];
    pc = ib_data_out[31:16];
    e_rt = ib_data_out[3:0];
    if (reset) begin
      chk("pop_in_reset", 32'(ib_pop), 32'(0));
      chk("alu_in_reset", 32'(alu_issue), 32'(0));
      chk("ld_in_reset", 32'(ld_issue), 32'(0));
      return;
    end
    if (!m_flush && !m_halted && !ib_empty) begin
      case (op)
        4'd0: begin
          av = {8'h0, ib_data_out[11:4]};
          if (alu_rs_avail) begin e_pop = 1; e_alu = 1; e_ren = 1; e_tag = alu_rs_tag; end
        end
        4'd1: begin
          rd(ra, ab, as_, av); rd(rb, bb, bs, bv);
          if (alu_rs_avail) begin e_pop = 1; e_alu = 1; e_ren = 1; e_tag = alu_rs_tag; end
        end
        4'd4: begin
          rd(ra, ab, as_, av);
          if (ld_rs_avail) begin e_pop = 1; e_ld = 1; e_ren = 1; e_tag = ld_rs_tag; end
        end
        4'd2: begin e_pop = 1; n_flush = 1; n_target = {4'h0, ib_data_out[11:0]}; end
        4'd5: begin
          rd(ra, ab, as_, av); rd(rb, bb, bs, bv);
          if (!ab && !bb) begin
            e_pop = 1;
            if (av == bv) begin
              off = ib_data_out[3] ? int'(ib_data_out[3:0]) - 16 : int'(ib_data_out[3:0]);
              n_flush = 1;
              n_target = 16'(int'(pc) + 1 + off);
            end
          end
        end
        4'd3: begin e_pop = 1; n_halt = 1; end
        default: e_pop = 1;
      endcase
    end
    chk("ib_pop", 32'(ib_pop), 32'(e_pop));
    chk("alu_issue", 32'(alu_issue), 32'(e_alu));
    chk("ld_issue", 32'(ld_issue), 32'(e_ld));
    chk("branch_taken", 32'(branch_taken), 32'(m_flush));
    chk("ib_flush", 32'(ib_flush), 32'(m_flush));
    chk("branch_target", 32'(branch_target), 32'(m_target));
    chk("halted", 32'(halted), 32'(m_halted));
    if (e_alu || e_ld) begin
      chk("issue_op", 32'(issue_op), 32'(op));
      chk("a_busy", 32'(issue_a_busy), 32'(ab));
      chk("b_busy", 32'(issue_b_busy), 32'(bb));
      if (ab) chk("a_src", 32'(issue_a_src), 32'(as_));
      else    chk("a_val", 32'(issue_a_val), 32'(av));
      if (bb) chk("b_src", 32'(issue_b_src), 32'(bs));
      else    chk("b_val", 32'(issue_b_val), 32'(bv));
    end
  endtask

  // Commit the model's next state, then move to the next falling edge.
  task automatic advance();
    bit was_flush;
    was_flush = m_flush;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin m_busy[i] = 0; m_src[i] = '0; m_val[i] = '0; end
      m_flush = 0; m_halted = 0; m_target = '0;
      pend.delete();
    end else begin
      if (cdb_valid) begin
        for (int i = 0; i < 16; i++)
          if (m_busy[i] && m_src[i] == cdb_tag) begin m_busy[i] = 0; m_val[i] = cdb_data; end
        for (int i = pend.size() - 1; i >= 0; i--)
          if (pend[i] == cdb_tag) pend.delete(i);
      end
      if (e_ren) begin m_busy[e_rt] = 1; m_src[e_rt] = e_tag; pend.push_back(e_tag); end
      m_flush = n_flush; m_halted = n_halt; m_target = n_target;
      if (e_pop && q.size() != 0) void'(q.pop_front());
      if (was_flush) q.delete();
    end
    @(negedge clk);
  endtask

  task automatic step();
    eval_cycle();
    advance();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [3:0] op, ra, rb, rt;
    int sel;
    sel = $urandom_range(0, 19);
    ra = 4'($urandom_range(0, 3)); rb = 4'($urandom_range(0, 3)); rt = 4'($urandom_range(0, 5));
    if (sel < 5)       op = 4'd0;
    else if (sel < 10) op = 4'd1;
    else if (sel < 13) op = 4'd4;
    else if (sel < 16) begin op = 4'd5; rt = 4'($urandom_range(0, 15)); end
    else if (sel == 16) op = 4'd2;
    else if (sel == 17) op = 4'd3;
    else if (sel == 18) op = 4'd7;
    else               op = 4'd15;
    if (op == 4'd0) return {16'($urandom), op, 8'($urandom_range(0, 3)), rt};
    if (op == 4'd2) return {16'($urandom), op, 12'($urandom)};
    return {16'($urandom), op, ra, rb, rt};
  endfunction

  int halt_cnt;
  int idx;

  initial begin
    reset = 1; gate = 0; cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
    alu_rs_avail = 1; alu_rs_tag = 15'd3; ld_rs_avail = 1; ld_rs_tag = 15'd8;
    ib_empty = 1; ib_data_out = '0;
    @(negedge clk);
    step(); step();
    reset = 0;

    // Reset state
    eval_cycle();
    chk("lit_reset_pop", 32'(ib_pop), 32'(0));
    chk("lit_reset_halted", 32'(halted), 32'(0));
    chk("lit_reset_target", 32'(branch_target), 32'h0);
    advance();

    // mov r1,#5 with ALU tag 3
    q.push_back(32'h0000_0051);
    eval_cycle();
    chk("lit_mov_pop", 32'(ib_pop), 32'(1));
    chk("lit_mov_issue", 32'(alu_issue), 32'(1));
    chk("lit_mov_aval", 32'(issue_a_val), 32'd5);
    advance();

    // add r2,r1,r1 with the r1 result on the CDB this very cycle
    q.push_back(32'h0000_1112);
    alu_rs_tag = 15'd4; cdb_valid = 1; cdb_tag = 15'd3; cdb_data = 16'd7;
    eval_cycle();
    chk("lit_add_abusy", 32'(issue_a_busy), 32'(0));
    chk("lit_add_aval", 32'(issue_a_val), 32'd7);
    chk("lit_add_bval", 32'(issue_b_val), 32'd7);
    advance();
    cdb_valid = 0;

    // ld r4,r2 waiting three cycles for a load station
    q.push_back(32'h0000_4204);
    ld_rs_avail = 0;
    repeat (3) begin
      eval_cycle();
      chk("lit_ld_stall", 32'(ib_pop), 32'(0));
      advance();
    end
    ld_rs_avail = 1; ld_rs_tag = 15'd9;
    eval_cycle();
    chk("lit_ld_issue", 32'(ld_issue), 32'(1));
    chk("lit_ld_abusy", 32'(issue_a_busy), 32'(1));
    chk("lit_ld_asrc", 32'(issue_a_src), 32'd4);
    advance();

    // jmp 0x0AB
    q.push_back(32'h0000_20AB);
    eval_cycle();
    chk("lit_jmp_pop", 32'(ib_pop), 32'(1));
    advance();
    eval_cycle();
    chk("lit_jmp_taken", 32'(branch_taken), 32'(1));
    chk("lit_jmp_flush", 32'(ib_flush), 32'(1));
    chk("lit_jmp_target", 32'(branch_target), 32'h00AB);
    advance();
    eval_cycle();
    chk("lit_jmp_after", 32'({branch_taken, ib_flush, ib_pop}), 32'(0));
    advance();

    // jeq r1,r2,-2 at pc 0x0010: r1=9 ready, r2 waits on tag 4
    q.push_back(32'h0000_0091);
    alu_rs_tag = 15'd5;
    step();
    cdb_valid = 1; cdb_tag = 15'd5; cdb_data = 16'd9;
    step();
    cdb_valid = 0;
    q.push_back(32'h0010_512E);
    repeat (4) begin
      eval_cycle();
      chk("lit_jeq_stall", 32'(ib_pop), 32'(0));
      advance();
    end
    cdb_valid = 1; cdb_tag = 15'd4; cdb_data = 16'd9;
    eval_cycle();
    chk("lit_jeq_pop", 32'(ib_pop), 32'(1));
    advance();
    cdb_valid = 0;
    eval_cycle();
    chk("lit_jeq_taken", 32'(branch_taken), 32'(1));
    chk("lit_jeq_target", 32'(branch_target), 32'h000F);
    advance();

    // halt, then an add that must wait for reset
    q.push_back(32'h0000_3000);
    q.push_back(32'h0000_1123);
    eval_cycle();
    chk("lit_halt_pop", 32'(ib_pop), 32'(1));
    advance();
    repeat (3) begin
      eval_cycle();
      chk("lit_halted", 32'(halted), 32'(1));
      chk("lit_halt_nopop", 32'(ib_pop), 32'(0));
      advance();
    end
    reset = 1;
    step();
    reset = 0;
    eval_cycle();
    chk("lit_rst_halted", 32'(halted), 32'(0));
    chk("lit_rst_add", 32'(alu_issue), 32'(1));
    advance();

    // Randomized traffic against the model
    halt_cnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      alu_rs_avail = ($urandom_range(0, 3) != 0);
      alu_rs_tag   = 15'($urandom_range(1, 6));
      ld_rs_avail  = ($urandom_range(0, 3) != 0);
      ld_rs_tag    = 15'($urandom_range(7, 10));
      cdb_valid = 0;
      if (pend.size() != 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, pend.size() - 1);
        cdb_valid = 1; cdb_tag = pend[idx];
      end else if ($urandom_range(0, 9) == 0) begin
        cdb_valid = 1; cdb_tag = 15'($urandom_range(0, 12));
      end
      cdb_data = 16'($urandom_range(0, 3));
      gate = ($urandom_range(0, 7) == 0);
      if (q.size() < 4 && $urandom_range(0, 1) == 0) q.push_back(rand_inst());
      if (m_halted) halt_cnt++;
      reset = (halt_cnt > 4) || ($urandom_range(0, 399) == 0);
      if (reset) halt_cnt = 0;
      step();
    end
    reset = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dispatch_unit.md
Name: dispatch_unit

Overview:
In-order dispatch stage of the Tomasulo core. It is the consumer (pop side) of the instruction buffer fifo that fetch fills. It reads the head entry, decodes it and renames registers through an internal busy/src/val register file. It issues to the ALU or load reservation stations, resolves jmp/jeq itself, and drives the branch redirect and buffer flush back to fetch and the fifo. It snoops the common data bus (CDB) to retire register tags.

Parameters:
NREGS, 16, number of architectural registers (4-bit specifiers)
TAGW, 15, reservation-station tag width (matches the 15-bit src field)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ib_empty  in  1  instruction buffer empty
ib_data_out  in  32  head entry {pc[31:16], inst[15:0]}, valid while !ib_empty (show-ahead)
ib_pop  out  1  head consumed this cycle; fifo advances at next edge (combinational)
ib_flush  out  1  flush buffer (registered)
branch_taken  out  1  redirect fetch (registered)
branch_target  out  16  redirect pc (registered)
alu_rs_avail  in  1  ALU station free
alu_rs_tag  in  TAGW  tag of that free ALU station
ld_rs_avail  in  1  load station free
ld_rs_tag  in  TAGW  tag of that free load station
alu_issue  out  1  issue strobe to ALU stations
ld_issue  out  1  issue strobe to load stations
issue_op  out  4  opcode
issue_a_busy, issue_b_busy  out  1 each  operand waiting on tag
issue_a_src, issue_b_src  out  TAGW each  producer tag
issue_a_val, issue_b_val  out  16 each  operand value when not busy
cdb_valid  in  1  broadcast valid
cdb_tag  in  TAGW  producing tag
cdb_data  in  16  result
halted  out  1  halt reached

Behaviour:
- Instruction fields: op[15:12], ra[11:8], rb[7:4], rt[3:0].
  - 0=mov: rt<=imm8 = inst[11:4] zero-extended. Issued to ALU with A = imm (not busy) and B = 0 (not busy).
  - 1=add: rt<=ra+rb. Issued to ALU.
  - 4=ld: rt<=mem[ra]. Issued to load; B = 0 (not busy).
  - 2=jmp: target = {4'b0, inst[11:0]}.
  - 5=jeq: if val(ra)==val(rb), target = pc+1+sext(inst[3:0]) mod 2^16.
  - 3=halt.
  - Any other opcode is popped and discarded as a nop.
- Register file: NREGS entries, each {busy, src[TAGW-1:0], val[15:0]}. Reset clears every entry to 0.
- CDB update: when cdb_valid, every entry with busy && src==cdb_tag gets busy<=0 and val<=cdb_data.
- CDB bypass: if a source operand being issued this cycle is busy and its src equals cdb_tag while cdb_valid, drive it as not busy with value cdb_data.
- States:
  - RUN: head visible and the instruction can proceed, so ib_pop=1 in the same cycle.
    - add/mov: also requires alu_rs_avail. Asserts alu_issue and sets rt to {busy=1, src=alu_rs_tag}.
    - ld: also requires ld_rs_avail. Asserts ld_issue and sets rt to {busy=1, src=ld_rs_tag}.
    - If the required station is unavailable: stall, no pop, no issue.
    - Rename beats a same-cycle CDB write to rt. An instruction whose rt equals a source reads the pre-rename source.
    - jmp: pop, go to FLUSH.
    - jeq: stall while either operand is busy after the CDB bypass. When both are ready: pop; go to FLUSH if equal, otherwise continue in RUN.
    - halt: pop, go to HALT.
  - FLUSH (exactly 1 cycle):
    - branch_taken=1, ib_flush=1, branch_target=target. These are registered, so they are visible in the cycle after the pop.
    - No pop and no issue; return to RUN.
  - HALT: halted=1; nothing popped or issued until reset. CDB updates continue.
- ib_empty: no pop, no issue, all strobes 0.
- Outputs are 0 at reset and when idle: ib_pop, ib_flush, branch_taken, alu_issue, ld_issue, halted. branch_target resets to 0.
- Issue bus values are don't-care when no strobe is asserted.
- Reset mid-operation wins over everything: it forces RUN, drops any pending flush and clears the register file.

Test Plan:
- Reset, then mov r1,#5 with alu_rs_tag=3 -> same cycle ib_pop=1, alu_issue=1, issue_a_val=5; next cycle r1={busy,src=3}.
- add r2,r1,r1 with r1 busy src=3; same cycle cdb_valid, tag=3, data=7 -> issue_a/b_busy=0, values=7; r2 renamed to the ALU tag.
- ld r4,r2 with ld_rs_avail=0 for 3 cycles -> no pop for 3 cycles; pops on the cycle avail rises, ld_issue=1.
- jmp 0x0AB -> pop cycle N; cycle N+1 branch_taken=1, ib_flush=1, branch_target=0x00AB; cycle N+2 all low.
- jeq r1,r2,off=-2 at pc=0x0010, r2 busy until CDB at cycle 5, both 9 -> stall until cycle 5, then redirect target 0x000F.
- halt followed by add in the buffer -> halted=1, add never popped; reset asserted -> halted=0 and the add is dispatched.
